// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Function : Shares one cacheline memory port between the I-cache miss path
//             and the D-cache miss/writeback path. One requester is granted
//             per transaction; all pmem-side outputs and responses are
//             registered.
//  Options  : ARB_RR_EN - when defined, a same-cycle tie goes to the
//             requester not granted last (round-robin); otherwise the D side
//             always wins a tie.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_address,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_address,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT_I = 2'd1,
        ST_GRANT_D = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic              r_pmem_read;
    logic              r_pmem_write;
    logic [ADDR_W-1:0] r_pmem_address;
    logic [LINE_W-1:0] r_pmem_wdata;
    logic [LINE_W-1:0] r_i_rdata;
    logic [LINE_W-1:0] r_d_rdata;
    logic              r_i_resp;
    logic              r_d_resp;

    logic              w_pmem_read_nxt;
    logic              w_pmem_write_nxt;
    logic [ADDR_W-1:0] w_pmem_address_nxt;
    logic [LINE_W-1:0] w_pmem_wdata_nxt;
    logic [LINE_W-1:0] w_i_rdata_nxt;
    logic [LINE_W-1:0] w_d_rdata_nxt;
    logic              w_i_resp_nxt;
    logic              w_d_resp_nxt;

    logic              w_d_req;
    logic              w_pick_d;

    assign w_d_req = d_read | d_write;

`ifdef ARB_RR_EN
    // 1 = the D side held the most recent grant; resets to the I side.
    logic              r_last_d;
    logic              w_last_d_nxt;

    // On a tie the side that was not granted last goes first.
    assign w_pick_d = w_d_req & (~i_read | ~r_last_d);
`else
    assign w_pick_d = w_d_req;
`endif

    // Next-state and next-output decode; every target defaults to hold.
    always_comb begin
        w_state_nxt        = r_state;
        w_pmem_read_nxt    = r_pmem_read;
        w_pmem_write_nxt   = r_pmem_write;
        w_pmem_address_nxt = r_pmem_address;
        w_pmem_wdata_nxt   = r_pmem_wdata;
        w_i_rdata_nxt      = r_i_rdata;
        w_d_rdata_nxt      = r_d_rdata;
        w_i_resp_nxt       = 1'b0;
        w_d_resp_nxt       = 1'b0;
`ifdef ARB_RR_EN
        w_last_d_nxt       = r_last_d;
`endif
        case (r_state)
            ST_IDLE: begin
                if (w_pick_d) begin
                    // A simultaneous read+write is carried out as the write.
                    w_state_nxt        = ST_GRANT_D;
                    w_pmem_address_nxt = d_address;
                    w_pmem_wdata_nxt   = d_wdata;
                    w_pmem_write_nxt   = d_write;
                    w_pmem_read_nxt    = ~d_write;
`ifdef ARB_RR_EN
                    w_last_d_nxt       = 1'b1;
`endif
                end else if (i_read) begin
                    w_state_nxt        = ST_GRANT_I;
                    w_pmem_address_nxt = i_address;
                    w_pmem_read_nxt    = 1'b1;
                    w_pmem_write_nxt   = 1'b0;
`ifdef ARB_RR_EN
                    w_last_d_nxt       = 1'b0;
`endif
                end
            end
            ST_GRANT_I: begin
                if (pmem_resp) begin
                    w_state_nxt      = ST_DONE;
                    w_i_rdata_nxt    = pmem_rdata;
                    w_i_resp_nxt     = 1'b1;
                    w_pmem_read_nxt  = 1'b0;
                    w_pmem_write_nxt = 1'b0;
                end
            end
            ST_GRANT_D: begin
                if (pmem_resp) begin
                    w_state_nxt = ST_DONE;
                    // A writeback returns nothing, so the last read line stays.
                    if (!r_pmem_write) begin
                        w_d_rdata_nxt = pmem_rdata;
                    end
                    w_d_resp_nxt     = 1'b1;
                    w_pmem_read_nxt  = 1'b0;
                    w_pmem_write_nxt = 1'b0;
                end
            end
            ST_DONE: begin
                // Requests seen here belong to the finishing requester and are ignored.
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Registered pmem-side outputs, responses and returned lines.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pmem_read    <= 1'b0;
            r_pmem_write   <= 1'b0;
            r_pmem_address <= '0;
            r_pmem_wdata   <= '0;
            r_i_rdata      <= '0;
            r_d_rdata      <= '0;
            r_i_resp       <= 1'b0;
            r_d_resp       <= 1'b0;
        end else begin
            r_pmem_read    <= w_pmem_read_nxt;
            r_pmem_write   <= w_pmem_write_nxt;
            r_pmem_address <= w_pmem_address_nxt;
            r_pmem_wdata   <= w_pmem_wdata_nxt;
            r_i_rdata      <= w_i_rdata_nxt;
            r_d_rdata      <= w_d_rdata_nxt;
            r_i_resp       <= w_i_resp_nxt;
            r_d_resp       <= w_d_resp_nxt;
        end
    end

`ifdef ARB_RR_EN
    // Last-grant flag, updated on entry to a grant state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_d <= 1'b0;
        end else begin
            r_last_d <= w_last_d_nxt;
        end
    end
`endif

    assign pmem_read    = r_pmem_read;
    assign pmem_write   = r_pmem_write;
    assign pmem_address = r_pmem_address;
    assign pmem_wdata   = r_pmem_wdata;
    assign i_rdata      = r_i_rdata;
    assign d_rdata      = r_d_rdata;
    assign i_resp       = r_i_resp;
    assign d_resp       = r_d_resp;

`ifndef SYNTHESIS
    // Flag protocol misuse; the hardware behaviour in each case stays defined.
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(d_read && d_write))
                else $warning("mem_arbiter: d_read and d_write both high, handled as write");
            assert (!(r_state == ST_GRANT_I && !i_read))
                else $warning("mem_arbiter: i_read dropped while granted");
            assert (!(r_state == ST_GRANT_D && !w_d_req))
                else $warning("mem_arbiter: d request dropped while granted");
            assert (!((r_state == ST_IDLE || r_state == ST_DONE) && pmem_resp))
                else $warning("mem_arbiter: pmem_resp outside a grant ignored");
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Function : Self-checking bench for mem_arbiter. Directed scenarios plus
//             randomized rounds, checked against a transaction-level model of
//             the arbitration rules (winner choice, latch, response, rdata).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;
`ifdef ARB_RR_EN
    localparam bit RR_MODE = 1'b1;
`else
    localparam bit RR_MODE = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic              i_read = 1'b0;
    logic [ADDR_W-1:0] i_address = '0;
    logic [LINE_W-1:0] i_rdata;
    logic              i_resp;
    logic              d_read = 1'b0;
    logic              d_write = 1'b0;
    logic [ADDR_W-1:0] d_address = '0;
    logic [LINE_W-1:0] d_wdata = '0;
    logic [LINE_W-1:0] d_rdata;
    logic              d_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata = '0;
    logic              pmem_resp = 1'b0;

    int checks = 0;
    int failures = 0;

    // Reference model state
    bit                last_d = 1'b0;
    logic [LINE_W-1:0] exp_i_rdata = '0;
    logic [LINE_W-1:0] exp_d_rdata = '0;

    mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_read       (i_read),
        .i_address    (i_address),
        .i_rdata      (i_rdata),
        .i_resp       (i_resp),
        .d_read       (d_read),
        .d_write      (d_write),
        .d_address    (d_address),
        .d_wdata      (d_wdata),
        .d_rdata      (d_rdata),
        .d_resp       (d_resp),
        .pmem_read    (pmem_read),
        .pmem_write   (pmem_write),
        .pmem_address (pmem_address),
        .pmem_wdata   (pmem_wdata),
        .pmem_rdata   (pmem_rdata),
        .pmem_resp    (pmem_resp)
    );

    always #5 clk = ~clk;

    function automatic void chk(input string tag, input logic [LINE_W-1:0] obs,
                                input logic [LINE_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endfunction

    function automatic logic [LINE_W-1:0] rnd_line();
        logic [LINE_W-1:0] v;
        v = '0;
        for (int k = 0; k < LINE_W / 32; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    // Which side the arbiter should grant next, given who is pending.
    function automatic bit d_wins(input bit i_pend, input bit d_pend);
        if (!d_pend) return 1'b0;
        if (!i_pend) return 1'b1;
        return RR_MODE ? !last_d : 1'b1;
    endfunction

    function automatic void chk_all_zero(input string tag);
        chk({tag, "_i_resp"}, i_resp, 0);
        chk({tag, "_d_resp"}, d_resp, 0);
        chk({tag, "_pmem_read"}, pmem_read, 0);
        chk({tag, "_pmem_write"}, pmem_write, 0);
        chk({tag, "_pmem_address"}, pmem_address, 0);
        chk({tag, "_pmem_wdata"}, pmem_wdata, 0);
        chk({tag, "_i_rdata"}, i_rdata, 0);
        chk({tag, "_d_rdata"}, d_rdata, 0);
    endfunction

    // Act as the adaptor for one transaction of the expected side. Entered
    // just after a rising edge with the arbiter idle; returns just after the
    // edge that ends the response cycle.
    task automatic serve(input bit is_d, input int lat, input logic [LINE_W-1:0] rd,
                         input bit drop);
        int n;
        bit wr;
        logic [ADDR_W-1:0] ea;
        logic [LINE_W-1:0] ew;
        wr = is_d && d_write;
        ea = is_d ? d_address : i_address;
        ew = d_wdata;
        n  = 0;
        @(negedge clk);
        while (!(pmem_read || pmem_write) && n < 40) begin
            chk("resp_while_idle", {i_resp, d_resp}, 0);
            n++;
            @(negedge clk);
        end
        chk("grant_latency", n, 1);
        if (n >= 40) return;
        last_d = is_d;
        for (int c = 0; c < lat; c++) begin
            chk("pmem_read", pmem_read, !wr);
            chk("pmem_write", pmem_write, wr);
            chk("pmem_address", pmem_address, ea);
            if (wr) chk("pmem_wdata", pmem_wdata, ew);
            chk("resp_during_grant", {i_resp, d_resp}, 0);
            if (c == 0) begin
                // Granted side changes its inputs: the latched values must hold.
                if (is_d) begin
                    d_address = $urandom;
                    d_wdata   = rnd_line();
                end else begin
                    i_address = $urandom;
                end
            end
            if (c < lat - 1) @(negedge clk);
        end
        pmem_rdata = rd;
        pmem_resp  = 1'b1;
        @(posedge clk);
        #1;
        pmem_resp  = 1'b0;
        pmem_rdata = rnd_line();
        @(negedge clk);
        chk("i_resp", i_resp, !is_d);
        chk("d_resp", d_resp, is_d);
        chk("pmem_idle_in_done", {pmem_read, pmem_write}, 0);
        if (!wr) begin
            if (is_d) exp_d_rdata = rd;
            else      exp_i_rdata = rd;
        end
        chk("i_rdata", i_rdata, exp_i_rdata);
        chk("d_rdata", d_rdata, exp_d_rdata);
        @(posedge clk);
        #1;
        if (drop) begin
            if (is_d) begin
                d_read  = 1'b0;
                d_write = 1'b0;
            end else begin
                i_read = 1'b0;
            end
        end
    endtask

    // Raise the requested sides together and serve them in model order;
    // the D side stays high across its n_d back-to-back transactions.
    task automatic run_round(input int n_i, input int n_d, input bit d_wr,
                             input bit d_rd, input int lat);
        if (n_i > 0) begin
            i_read    = 1'b1;
            i_address = $urandom;
        end
        if (n_d > 0) begin
            d_read    = d_rd;
            d_write   = d_wr;
            d_address = $urandom;
            d_wdata   = rnd_line();
        end
        while (n_i + n_d > 0) begin
            if (d_wins(n_i > 0, n_d > 0)) begin
                n_d--;
                serve(1'b1, lat, rnd_line(), n_d == 0);
            end else begin
                n_i--;
                serve(1'b0, lat, rnd_line(), 1'b1);
            end
        end
    endtask

    initial begin
        // Reset state
        #1 rst_n = 1'b0;
        #1 chk_all_zero("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // I-cache read of 0x40, adaptor answers after 4 cycles
        i_read    = 1'b1;
        i_address = 32'h0000_0040;
        serve(1'b0, 4, {32{8'hA5}}, 1'b1);

        // D-cache writeback of 0x1000
        d_write   = 1'b1;
        d_read    = 1'b0;
        d_address = 32'h0000_1000;
        d_wdata   = {8{32'hDEAD_BEEF}};
        serve(1'b1, 3, rnd_line(), 1'b1);

        // Same-cycle tie (last grant is D here)
        run_round(1, 1, 1'b0, 1'b1, 2);

        // D back-to-back with I waiting, starting from last grant = I
        run_round(1, 0, 1'b0, 1'b0, 1);
        run_round(1, 3, 1'b0, 1'b1, 2);

        // Read and write together: carried out as a write, d_rdata unchanged
        run_round(0, 1, 1'b1, 1'b1, 3);

        // Asynchronous reset in the middle of a D grant
        d_read    = 1'b0;
        d_write   = 1'b1;
        d_address = 32'h0000_1000;
        d_wdata   = rnd_line();
        @(negedge clk);
        chk("rst_pre_grant", pmem_write, 0);
        @(negedge clk);
        chk("rst_granted", pmem_write, 1);
        #1 rst_n = 1'b0;
        d_write = 1'b0;
        #1 chk_all_zero("async_rst");
        exp_i_rdata = '0;
        exp_d_rdata = '0;
        last_d      = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("post_rst_quiet", {i_resp, d_resp, pmem_read, pmem_write}, 0);
        end
        @(posedge clk);
        #1;

        // Randomized rounds
        for (int r = 0; r < 25; r++) begin
            int ni, nd;
            bit wr;
            ni = int'($urandom_range(0, 1));
            nd = int'($urandom_range(0, 2));
            if (ni + nd == 0) ni = 1;
            wr = 1'($urandom_range(0, 1));
            run_round(ni, nd, wr, !wr, int'($urandom_range(1, 5)));
        end

        // Quiet tail: no stray response or request
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("tail_quiet", {i_resp, d_resp, pmem_read, pmem_write}, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
